// File: rtl/farm_sensor_req.sv
// Farm-road vehicle detector front end: synchronises and debounces the loop detector,
// queues arrivals and raises the car request until the controller grants farm green.
module farm_sensor_req #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned SERVE_CYC = 3,
    parameter int unsigned MAX_WAIT  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             loop_raw,
    input  logic             farm_green,
    output logic             car_req,
    output logic             car_det,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic             starve
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
    localparam int unsigned SRV_W  = (SERVE_CYC > 1) ? $clog2(SERVE_CYC) : 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t              state;
    logic                sync1;
    logic                sync2;
    logic                filt;
    logic                filt_prev;
    logic [DEB_W-1:0]    deb_cnt;
    logic [SRV_W-1:0]    serve_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                serve_tick;
    logic                cnt_full;
    logic                ovf_hit;
    logic [CNT_W-1:0]    cnt_next;

    // Queue update: an arrival and a serve tick in the same cycle cancel out.
    always_comb begin
        serve_tick = (state == SERVE) && farm_green && (serve_cnt == SRV_W'(SERVE_CYC - 1));
        cnt_full   = (car_count == CNT_MAX);
        ovf_hit    = car_det && !serve_tick && cnt_full;
        cnt_next   = car_count;
        if (car_det && !serve_tick && !cnt_full) begin
            cnt_next = car_count + CNT_W'(1);
        end else if (!car_det && serve_tick && (car_count != '0)) begin
            cnt_next = car_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            filt      <= 1'b0;
            filt_prev <= 1'b0;
            deb_cnt   <= '0;
            serve_cnt <= '0;
            wait_cnt  <= '0;
            car_req   <= 1'b0;
            car_det   <= 1'b0;
            car_count <= '0;
            overflow  <= 1'b0;
            starve    <= 1'b0;
        end else if (ena) begin
            sync1 <= loop_raw;
            sync2 <= sync1;

            // Level change accepted only once the mismatch has outlasted the debounce window.
            if (sync2 != filt) begin
                if (deb_cnt == DEB_W'(DEB_CYC)) begin
                    filt    <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end

            filt_prev <= filt;
            car_det   <= filt & ~filt_prev;
            car_count <= cnt_next;
            overflow  <= overflow | ovf_hit;

            case (state)
                IDLE: begin
                    if (cnt_next != '0) begin
                        state   <= PEND;
                        car_req <= 1'b1;
                    end
                end
                PEND: begin
                    if (farm_green) begin
                        state    <= SERVE;
                        car_req  <= 1'b0;
                        wait_cnt <= '0;
                        starve   <= 1'b0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        starve <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                SERVE: begin
                    if (farm_green) begin
                        serve_cnt <= serve_tick ? '0 : serve_cnt + SRV_W'(1);
                    end else begin
                        serve_cnt <= '0;
                        if (cnt_next != '0) begin
                            state   <= PEND;
                            car_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    car_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_farm_sensor_req.sv
// Self-checking bench for farm_sensor_req: vector table for arrivals/glitches plus
// hand-timed sequences for service, starvation, saturation and coincident events.
module tb_farm_sensor_req;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       loop_raw;
    logic       farm_green;
    logic       car_req;
    logic       car_det;
    logic [3:0] car_count;
    logic       overflow;
    logic       starve;

    int tests;
    int fails;
    int det_seen;

    farm_sensor_req dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .loop_raw   (loop_raw),
        .farm_green (farm_green),
        .car_req    (car_req),
        .car_det    (car_det),
        .car_count  (car_count),
        .overflow   (overflow),
        .starve     (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count detection pulses away from the active edge.
    always @(negedge clk) if (car_det) det_seen <= det_seen + 1;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    typedef struct {
        string      name;
        int         high;
        int         pulses;
        logic [7:0] exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    function automatic logic [7:0] pk(input logic req, input logic det, input logic [3:0] cnt,
                                      input logic ovf, input logic stv);
        return {req, det, cnt, ovf, stv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {req,det,cnt,ovf,stv}=%b_%b_%h_%b_%b expected %b_%b_%h_%b_%b",
                     name, act[7], act[6], act[5:2], act[1], act[0],
                     exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Push expectation, advance n edges, then pop and compare against the DUT.
    task automatic run_check(input string name, input int n, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        repeat (n) step();
        e = exp_q.pop_front();
        cmp(e.name, pk(car_req, car_det, car_count, overflow, starve), e.exp);
    endtask

    task automatic arrive(input int high, input int low);
        loop_raw = 1'b1;
        repeat (high) step();
        loop_raw = 1'b0;
        repeat (low) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests      = 0;
        fails      = 0;
        det_seen   = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        loop_raw   = 1'b1;
        farm_green = 1'b0;

        vecs[0] = '{"glitch1",  1, 0, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0)};
        vecs[1] = '{"glitch2",  2, 0, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0)};
        vecs[2] = '{"glitch3",  3, 0, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0)};
        vecs[3] = '{"arrive1", 10, 1, pk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0)};
        vecs[4] = '{"arrive2", 10, 1, pk(1'b1, 1'b0, 4'd2, 1'b0, 1'b1)};

        run_check("reset", 1, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        loop_raw = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 5; i++) begin
            det_seen = 0;
            arrive(vecs[i].high, 15);
            run_check(vecs[i].name, 0, vecs[i].exp);
            cmp_int({vecs[i].name, "_pulses"}, det_seen, vecs[i].pulses);
        end

        // Two queued cars served three green cycles each, then back to idle.
        farm_green = 1'b1;
        run_check("serve_enter",   1, pk(1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
        run_check("serve_partial", 2, pk(1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
        run_check("serve_tick1",   1, pk(1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
        run_check("serve_tick2",   3, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        step();
        farm_green = 1'b0;
        run_check("serve_idle",    1, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));

        // One car left waiting until starve, then a too-short green.
        arrive(10, 15);
        run_check("starve_pre",    3, pk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
        run_check("starve_set",    1, pk(1'b1, 1'b0, 4'd1, 1'b0, 1'b1));
        farm_green = 1'b1;
        run_check("partial_enter", 1, pk(1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
        step();
        farm_green = 1'b0;
        run_check("partial_back",  1, pk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
        farm_green = 1'b1;
        run_check("drain",         4, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        farm_green = 1'b0;
        run_check("drain_idle",    1, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));

        // Fill the queue to saturation, then one more arrival.
        for (int i = 0; i < 15; i++) arrive(8, 8);
        run_check("sat_full", 0, pk(1'b1, 1'b0, 4'd15, 1'b0, 1'b1));
        det_seen = 0;
        arrive(8, 8);
        run_check("sat_over", 0, pk(1'b1, 1'b0, 4'd15, 1'b1, 1'b1));
        cmp_int("sat_det_pulse", det_seen, 1);

        // Arrival whose count update lands on the same edge as a serve tick.
        loop_raw = 1'b1;
        repeat (5) step();
        farm_green = 1'b1;
        repeat (3) step();
        loop_raw = 1'b0;
        run_check("simul",      1, pk(1'b0, 1'b0, 4'd15, 1'b1, 1'b0));
        run_check("simul_next", 3, pk(1'b0, 1'b0, 4'd14, 1'b1, 1'b0));

        ena = 1'b0;
        run_check("freeze", 6, pk(1'b0, 1'b0, 4'd14, 1'b1, 1'b0));
        ena        = 1'b1;
        farm_green = 1'b0;

        rst_n = 1'b0;
        run_check("mid_reset", 1, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        repeat (2) step();

        // Exact arrival latency from the first sampled high edge.
        loop_raw = 1'b1;
        run_check("lat_pre", 7, pk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
        run_check("lat_det", 1, pk(1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
        run_check("lat_cnt", 1, pk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
        loop_raw = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
